// File: rtl/sigmoid_mac_pipe.sv
// sigmoid_mac_pipe: pipelined signed-weight x unsigned-activation MAC neuron with hard-sigmoid/ReLU output
// Ports: clk, rst (sync, active-high), clear (sync flush), act_mode (0 sigmoid, 1 ReLU),
//   in_valid/in_ready/in_last + weights/inputs/bias beat interface,
//   accum_out (live accumulator), out/out_valid/out_ready result handshake.
// Optional: define SIGMOID_MAC_SAT_EN for a saturating accumulator instead of wrapping.
module sigmoid_mac_pipe #(
  parameter int LANES     = 4,
  parameter int W_W       = 4,
  parameter int IN_W      = 4,
  parameter int BIAS_W    = 4,
  parameter int ACC_W     = 16,
  parameter int OUT_W     = 4,
  parameter int ACT_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    act_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [LANES*W_W-1:0]    weights,
  input  logic [LANES*IN_W-1:0]   inputs,
  input  logic [BIAS_W-1:0]       bias,
  output logic [ACC_W-1:0]        accum_out,
  output logic [OUT_W-1:0]        out,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int P_W = W_W + IN_W + 1;
  localparam int S_W = P_W + $clog2(LANES);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << OUT_W) - 1);
  localparam logic signed [ACC_W-1:0] MID_V = ACC_W'(1 << (OUT_W - 1));
  logic wait_q, wait_d, mid_q, mid_d, mode_q, mode_d;
  logic signed [BIAS_W-1:0] bias_q, bias_d;
  logic v0_q, v0_d, f0_q, f0_d, l0_q, l0_d;
  logic v1_q, v1_d, f1_q, f1_d, l1_q, l1_d;
  logic v2_q, v2_d, f2_q, f2_d, l2_q, l2_d;
  logic [LANES*W_W-1:0] w0_q, w0_d;
  logic [LANES*IN_W-1:0] x0_q, x0_d;
  logic signed [P_W-1:0] prod_q [LANES];
  logic signed [P_W-1:0] prod_d [LANES];
  logic signed [S_W-1:0] sum_q, sum_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, base, add, a, t;
  logic [OUT_W-1:0] out_q, out_d;
  logic out_valid_q, out_valid_d;
  logic accept, fire;
`ifdef SIGMOID_MAC_SAT_EN
  logic signed [ACC_W:0] wide;
`endif
  // a closed vector blocks new beats until its result has been consumed
  assign in_ready  = ~wait_q & ~rst & ~clear;
  assign accept    = in_valid & in_ready;
  assign fire      = v2_q & ~clear;
  assign accum_out = acc_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  always_comb begin
    v0_d = accept;
    f0_d = ~mid_q;
    l0_d = in_last;
    w0_d = weights;
    x0_d = inputs;
    v1_d = v0_q & ~clear;
    f1_d = f0_q;
    l1_d = l0_q;
    for (int k = 0; k < LANES; k++)
      prod_d[k] = P_W'($signed(w0_q[k*W_W +: W_W])) * $signed(P_W'(x0_q[k*IN_W +: IN_W]));
    v2_d = v1_q & ~clear;
    f2_d = f1_q;
    l2_d = l1_q;
    sum_d = '0;
    for (int k = 0; k < LANES; k++)
      sum_d = sum_d + S_W'(prod_q[k]);
    base = f2_q ? ACC_W'(bias_q) : acc_q;
`ifdef SIGMOID_MAC_SAT_EN
    wide = (ACC_W+1)'(base) + (ACC_W+1)'(sum_q);
    add  = (wide[ACC_W] != wide[ACC_W-1]) ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
`else
    add  = base + ACC_W'(sum_q);
`endif
    acc_d = clear ? '0 : v2_q ? add : acc_q;
    a     = acc_d >>> ACT_SHIFT;
    t     = mode_q ? a : a + MID_V;
    out_d = (fire & l2_q) ? (t < 0 ? '0 : t > MAX_V ? OUT_W'(MAX_V) : OUT_W'(t)) : out_q;
    out_valid_d = clear ? 1'b0 : (fire & l2_q) | (out_valid_q & ~out_ready);
    wait_d = clear ? 1'b0 : (accept & in_last) ? 1'b1 : (out_valid_q & out_ready) ? 1'b0 : wait_q;
    mid_d  = clear ? 1'b0 : accept ? ~in_last : mid_q;
    // bias and mode are only taken from the first beat of a vector
    bias_d = (accept & ~mid_q) ? bias : bias_q;
    mode_d = (accept & ~mid_q) ? act_mode : mode_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {v0_q, f0_q, l0_q, v1_q, f1_q, l1_q, v2_q, f2_q, l2_q} <= '0;
      w0_q        <= '0;
      x0_q        <= '0;
      prod_q      <= '{default: '0};
      sum_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wait_q      <= 1'b0;
      mid_q       <= 1'b0;
      bias_q      <= '0;
      mode_q      <= 1'b0;
    end else begin
      {v0_q, f0_q, l0_q} <= {v0_d, f0_d, l0_d};
      {v1_q, f1_q, l1_q} <= {v1_d, f1_d, l1_d};
      {v2_q, f2_q, l2_q} <= {v2_d, f2_d, l2_d};
      w0_q        <= w0_d;
      x0_q        <= x0_d;
      prod_q      <= prod_d;
      sum_q       <= sum_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      wait_q      <= wait_d;
      mid_q       <= mid_d;
      bias_q      <= bias_d;
      mode_q      <= mode_d;
    end
  end
endmodule

// File: tb/tb_sigmoid_mac_pipe.sv
// tb_sigmoid_mac_pipe: table-driven directed checks of sigmoid_mac_pipe
module tb_sigmoid_mac_pipe;
  logic clk = 1'b0;
  logic rst, clear, act_mode, in_valid, in_last, out_ready;
  logic [15:0] weights, inputs;
  logic [3:0] bias;
  logic in_ready, out_valid;
  logic [15:0] accum_out;
  logic [3:0] out;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [15:0] w;
    logic [15:0] x;
    logic [3:0]  bias;
    logic        mode;
    int          n;
    int          acc;
    int          out;
  } vec_t;
  vec_t tbl [9];
  always #5 clk = ~clk;
  sigmoid_mac_pipe dut (
    .clk(clk), .rst(rst), .clear(clear), .act_mode(act_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .weights(weights), .inputs(inputs), .bias(bias),
    .accum_out(accum_out), .out(out), .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input vec_t v, input bit hs);
    int cnt;
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      in_last  = (i == v.n - 1);
      weights  = v.w;
      inputs   = v.x;
      bias     = (i == 0) ? v.bias : ~v.bias;
      act_mode = (i == 0) ? v.mode : ~v.mode;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("in_ready_after_last", int'(in_ready), 0);
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("latency", cnt, 3);
    chk("accum_out", int'($signed(accum_out)), v.acc);
    chk("out", int'(out), v.out);
    if (hs) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_after_hs", int'(out_valid), 0);
      chk("in_ready_after_hs", int'(in_ready), 1);
    end
  endtask
  initial begin
    tbl[0] = '{16'h4321, 16'h1111, 4'hE, 1'b0, 1, 8, 8};
    tbl[1] = '{16'h7777, 16'hFFFF, 4'h0, 1'b0, 36, 15120, 15};
    tbl[2] = '{16'h7777, 16'hFFFF, 4'h0, 1'b1, 36, 15120, 15};
    tbl[3] = '{16'h8888, 16'hFFFF, 4'h0, 1'b0, 2, -960, 0};
    tbl[4] = '{16'h8888, 16'hFFFF, 4'h0, 1'b1, 2, -960, 0};
`ifdef SIGMOID_MAC_SAT_EN
    tbl[5] = '{16'h7777, 16'hFFFF, 4'h0, 1'b0, 79, 32767, 15};
`else
    tbl[5] = '{16'h7777, 16'hFFFF, 4'h0, 1'b0, 79, -32356, 0};
`endif
    tbl[6] = '{16'h4321, 16'h1111, 4'h7, 1'b1, 2, 27, 1};
    tbl[7] = '{16'hFFFF, 16'h2222, 4'h8, 1'b0, 3, -32, 6};
    tbl[8] = '{16'h7777, 16'h1111, 4'h5, 1'b1, 3, 89, 5};
    rst = 1'b1; clear = 1'b0; act_mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; weights = '0; inputs = '0; bias = '0;
    tick();
    tick();
    chk("rst_accum", int'(accum_out), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", int'(in_ready), 1);
    tick();
    foreach (tbl[i]) run_vec(tbl[i], 1'b1);
    run_vec(tbl[0], 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_out", int'(out), 8);
      chk("hold_valid_ready", int'({out_valid, in_ready}), 2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_hs_valid", int'(out_valid), 0);
    chk("single_hs_ready", int'(in_ready), 1);
    repeat (3) tick();
    chk("no_second_result", int'(out_valid), 0);
    weights = 16'h7777; inputs = 16'hFFFF; bias = 4'h0; act_mode = 1'b0;
    in_valid = 1'b1; in_last = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    in_last = 1'b1;
    #1;
    chk("clear_in_ready", int'(in_ready), 0);
    tick();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("clear_accum", int'(accum_out), 0);
    chk("clear_out_valid", int'(out_valid), 0);
    repeat (4) tick();
    chk("clear_flushed_accum", int'(accum_out), 0);
    chk("clear_flushed_valid", int'(out_valid), 0);
    chk("clear_in_ready_back", int'(in_ready), 1);
    run_vec('{16'h4321, 16'h1111, 4'h0, 1'b0, 1, 10, 8}, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
